// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: start/stall control, instruction-memory handshake and decoded fields.
// master = fetch unit side, slave = memory/control-unit side.
interface fetch_unit_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic               start;
  logic               stall;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_ack;
  logic               instr_valid;
  logic [2:0]         opcode;
  logic [2:0]         rd;
  logic [2:0]         rs1;
  logic [2:0]         rs2;
  logic [7:0]         imm;
  logic [ADDR_W-1:0]  pc;
  logic               halted;

  modport master (
    input  start, stall, imem_rdata, imem_ack,
    output imem_req, imem_addr, instr_valid, opcode, rd, rs1, rs2, imm, pc, halted
  );

  modport slave (
    output start, stall, imem_rdata, imem_ack,
    input  imem_req, imem_addr, instr_valid, opcode, rd, rs1, rs2, imm, pc, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch/decode FSM: ack at edge N gives instr_valid the next cycle (1 instr / 2 cycles peak).
// stall holds the decoded instruction; memory wait states are unbounded.
module fetch_unit #(
  parameter int                 ADDR_W    = 8,
  parameter int                 INSTR_W   = 16,
  parameter logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF
) (
  input logic           clk,
  input logic           rst,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_HALT
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = 1;

  state_t             r_state;
  state_t             w_next;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic               w_is_halt;
  logic               w_load;
  logic               w_req;
  logic               w_valid;
  logic               w_halted;

  assign w_is_halt = (r_ir == HALT_WORD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_req    = 1'b0;
    w_valid  = 1'b0;
    w_halted = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_FETCH;
      end
      S_FETCH: begin
        w_req = 1'b1;
        if (bus.imem_ack) begin
          w_load = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // A halt word is never presented downstream, so stall cannot block it.
        if (w_is_halt) begin
          w_next = S_HALT;
        end else begin
          w_valid = 1'b1;
          if (!bus.stall) w_next = S_FETCH;
        end
      end
      S_HALT: begin
        w_halted = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= '0;
      r_ir <= '0;
    end else if (w_load) begin
      r_ir <= bus.imem_rdata;
      r_pc <= r_pc + PC_ONE;
    end
  end

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_pc;
  assign bus.pc          = r_pc;
  assign bus.instr_valid = w_valid;
  assign bus.halted      = w_halted;
  assign bus.opcode      = r_ir[15:13];
  assign bus.rd          = r_ir[12:10];
  assign bus.rs1         = r_ir[9:7];
  assign bus.rs2         = r_ir[6:4];
  assign bus.imm         = r_ir[7:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: basic fetch, wait states, stall, NOP, halt, pc wrap and reset.
module tb_fetch_unit;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  fetch_unit_if #(.ADDR_W(8), .INSTR_W(16)) bus_if ();

  fetch_unit #(.ADDR_W(8), .INSTR_W(16), .HALT_WORD(16'hFFFF)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while in FETCH; returns at the negedge of the next FETCH.
  task automatic fetch_one(input logic [15:0] data);
    bus_if.imem_ack   = 1'b1;
    bus_if.imem_rdata = data;
    @(negedge clk);
    bus_if.imem_ack   = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst               = 1'b1;
    bus_if.start      = 1'b0;
    bus_if.stall      = 1'b0;
    bus_if.imem_ack   = 1'b0;
    bus_if.imem_rdata = 16'h0000;
    #1;
    check("rst_req",    bus_if.imem_req, 0);
    check("rst_valid",  bus_if.instr_valid, 0);
    check("rst_halted", bus_if.halted, 0);
    check("rst_pc",     bus_if.pc, 0);
    check("rst_fields", {bus_if.opcode, bus_if.rd, bus_if.rs1, bus_if.rs2, bus_if.imm}, 0);

    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    #1 check("idle_no_req", bus_if.imem_req, 0);

    // Basic fetch
    @(negedge clk);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    #1;
    check("fetch0_req",  bus_if.imem_req, 1);
    check("fetch0_addr", bus_if.imem_addr, 8'h00);
    bus_if.imem_ack   = 1'b1;
    bus_if.imem_rdata = 16'h0A50;
    @(negedge clk);
    bus_if.imem_ack = 1'b0;
    #1;
    check("basic_valid",  bus_if.instr_valid, 1);
    check("basic_opcode", bus_if.opcode, 3'd0);
    check("basic_rd",     bus_if.rd, 3'd2);
    check("basic_rs1",    bus_if.rs1, 3'd4);
    check("basic_rs2",    bus_if.rs2, 3'd5);
    check("basic_pc",     bus_if.pc, 8'h01);
    check("basic_noreq",  bus_if.imem_req, 0);

    // Wait states
    @(negedge clk);
    #1 check("ws_addr0", {bus_if.imem_req, bus_if.imem_addr}, {1'b1, 8'h01});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("ws_req_addr", {bus_if.imem_req, bus_if.imem_addr}, {1'b1, 8'h01});
      check("ws_novalid",  bus_if.instr_valid, 0);
    end
    bus_if.imem_ack   = 1'b1;
    bus_if.imem_rdata = 16'h8C7F;
    @(negedge clk);
    bus_if.imem_ack = 1'b0;
    bus_if.stall    = 1'b1;
    #1;
    check("ws_valid",  bus_if.instr_valid, 1);
    check("ws_opcode", bus_if.opcode, 3'd4);
    check("ws_rd",     bus_if.rd, 3'd3);
    check("ws_imm",    bus_if.imm, 8'h7F);
    check("ws_pc",     bus_if.pc, 8'h02);

    // Stall in DECODE, with a stray ack that must be ignored
    bus_if.imem_ack   = 1'b1;
    bus_if.imem_rdata = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("stall_valid",  bus_if.instr_valid, 1);
      check("stall_fields", {bus_if.opcode, bus_if.rd, bus_if.imm}, {3'd4, 3'd3, 8'h7F});
      check("stall_noreq",  bus_if.imem_req, 0);
      check("stall_pc",     bus_if.pc, 8'h02);
    end
    bus_if.imem_ack = 1'b0;
    bus_if.stall    = 1'b0;
    @(negedge clk);
    #1 check("unstall_fetch", {bus_if.imem_req, bus_if.imem_addr}, {1'b1, 8'h02});

    // Opcode 7 word that is not HALT_WORD behaves as a normal instruction
    bus_if.imem_ack   = 1'b1;
    bus_if.imem_rdata = 16'hE123;
    @(negedge clk);
    bus_if.imem_ack = 1'b0;
    #1;
    check("nop_valid",  bus_if.instr_valid, 1);
    check("nop_opcode", bus_if.opcode, 3'd7);
    check("nop_imm",    bus_if.imm, 8'h23);
    check("nop_halted", bus_if.halted, 0);

    // Halt, entered even with stall asserted
    @(negedge clk);
    #1 check("halt_fetch_addr", bus_if.imem_addr, 8'h03);
    bus_if.imem_ack   = 1'b1;
    bus_if.imem_rdata = 16'hFFFF;
    @(negedge clk);
    bus_if.imem_ack = 1'b0;
    bus_if.stall    = 1'b1;
    #1;
    check("halt_dec_valid",  bus_if.instr_valid, 0);
    check("halt_dec_halted", bus_if.halted, 0);
    @(negedge clk);
    #1;
    check("halt_halted", bus_if.halted, 1);
    check("halt_valid",  bus_if.instr_valid, 0);
    check("halt_req",    bus_if.imem_req, 0);
    bus_if.stall    = 1'b0;
    bus_if.start    = 1'b1;
    bus_if.imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check("halt_sticky", {bus_if.halted, bus_if.imem_req, bus_if.instr_valid, bus_if.pc},
                              {1'b1, 1'b0, 1'b0, 8'h04});
    end
    bus_if.start    = 1'b0;
    bus_if.imem_ack = 1'b0;

    // Walk pc up to 8'hFF then wrap
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    for (int i = 0; i < 255; i++) fetch_one(16'h0000);
    #1 check("pre_wrap", {bus_if.imem_req, bus_if.imem_addr, bus_if.pc}, {1'b1, 8'hFF, 8'hFF});
    bus_if.imem_ack   = 1'b1;
    bus_if.imem_rdata = 16'h2468;
    @(negedge clk);
    bus_if.imem_ack = 1'b0;
    #1;
    check("wrap_pc",     bus_if.pc, 8'h00);
    check("wrap_opcode", bus_if.opcode, 3'd1);
    @(negedge clk);
    #1 check("wrap_fetch", {bus_if.imem_req, bus_if.imem_addr}, {1'b1, 8'h00});

    // Reset mid-FETCH, then a late ack must have no effect
    rst = 1'b1;
    #1;
    check("midrst_req",    bus_if.imem_req, 0);
    check("midrst_pc",     bus_if.pc, 8'h00);
    check("midrst_opcode", bus_if.opcode, 3'd0);
    @(negedge clk);
    rst               = 1'b0;
    bus_if.imem_ack   = 1'b1;
    bus_if.imem_rdata = 16'h0A50;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check("late_ack", {bus_if.imem_req, bus_if.instr_valid, bus_if.pc, bus_if.rd},
                           {1'b0, 1'b0, 8'h00, 3'd0});
    end
    bus_if.imem_ack = 1'b0;
    bus_if.start    = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    #1 check("restart_fetch", {bus_if.imem_req, bus_if.imem_addr}, {1'b1, 8'h00});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the program-counter and instruction-address width.
REQ-002 Parameter INSTR_W, default 16, SHALL set the instruction width; the field map in REQ-020 assumes 16.
REQ-003 Parameter HALT_WORD, default 16'hFFFF, SHALL be the instruction encoding that stops fetching.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  leave IDLE and begin fetching at the current pc.
REQ-007 stall  input  1  downstream not ready; the presented instruction SHALL be held.
REQ-008 imem_req  output  1  instruction-memory read request.
REQ-009 imem_addr  output  ADDR_W  read address.
REQ-010 imem_rdata  input  INSTR_W  read data; valid when imem_ack=1.
REQ-011 imem_ack  input  1  read complete.
REQ-012 instr_valid  output  1  decoded fields are valid for downstream (control unit, register file).
REQ-013 opcode  output  3  opcode field, driven to the control unit.
REQ-014 rd, rs1, rs2  output  3 each  register-index fields.
REQ-015 imm  output  8  immediate field for MOV.
REQ-016 pc  output  ADDR_W  address of the next instruction to fetch.
REQ-017 halted  output  1  HALT_WORD has been decoded.

Function
REQ-018 The block SHALL implement a four-state FSM: IDLE, FETCH, DECODE and HALT.
REQ-019 In IDLE, start=1 SHALL move the FSM to FETCH on the next edge; start SHALL be ignored in every other state.
REQ-020 Field map: opcode=IR[15:13], rd=IR[12:10], rs1=IR[9:7], rs2=IR[6:4], imm=IR[7:0]; fields SHALL be driven from IR combinationally in all states.
REQ-021 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc, both held stable until imem_ack=1; wait time is unbounded.
REQ-022 On the FETCH edge with imem_ack=1: IR<=imem_rdata, pc<=pc+1 modulo 2^ADDR_W, FSM->DECODE.
REQ-023 imem_ack SHALL be ignored outside FETCH, and imem_req SHALL be 0 outside FETCH.
REQ-024 In DECODE with IR!=HALT_WORD, instr_valid SHALL be 1; an instruction is consumed on an edge where instr_valid=1 and stall=0, then FSM->FETCH.
REQ-025 In DECODE with stall=1, the FSM SHALL stay in DECODE with IR, fields and instr_valid unchanged.
REQ-026 In DECODE with IR==HALT_WORD, instr_valid SHALL be 0 and the FSM SHALL move to HALT on the next edge regardless of stall.
REQ-027 In HALT, halted SHALL be 1, instr_valid=0 and imem_req=0; HALT SHALL be left only by rst.
REQ-028 Latency: imem_ack at edge N SHALL give instr_valid=1 in the cycle after N; peak throughput SHALL be one instruction per 2 cycles.
REQ-029 pc SHALL wrap from 2^ADDR_W-1 to 0 with no flag or stall.
REQ-030 Opcode 3'b111 words other than HALT_WORD SHALL be presented as normal instructions (NOP).

Reset
REQ-031 rst=1 SHALL immediately, without a clock, force state=IDLE, pc=0, IR=0, imem_req=0, instr_valid=0 and halted=0; field outputs are then 0.
REQ-032 rst asserted mid-FETCH or mid-DECODE SHALL abandon the transaction; any later imem_ack SHALL have no effect.
REQ-033 After rst deasserts, the block SHALL stay in IDLE until start=1.

Verification
REQ-034 Basic fetch: rst, then start; ack at addr 0 with 16'h0A50 (ADD rd=2, rs1=4, rs2=5) -> next cycle instr_valid=1, opcode=0, rd=2, rs1=4, rs2=5, pc=1.
REQ-035 Wait states: hold imem_ack=0 for 5 cycles -> imem_req=1 and imem_addr constant throughout; ack with 16'h8C7F -> opcode=4, rd=3, imm=8'h7F.
REQ-036 Stall: stall=1 for 3 cycles during DECODE -> fields and instr_valid stable, imem_req=0; stall=0 -> FETCH follows on the next cycle.
REQ-037 Halt: fetch 16'hFFFF -> instr_valid stays 0, halted=1 one cycle later, no further imem_req; start pulses are ignored.
REQ-038 Wrap and reset: preload pc=8'hFF via fetch sequence -> after ack pc=0; assert rst mid-FETCH -> imem_req=0 immediately, pc=0, and a late ack changes nothing.
